// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache for the fetch stage.
// Hits return combinationally; misses stall and refill one line word by word over req/ready.
module icache_dm #(
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] instr,
    output logic        stall,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    output logic        state_dbg
);
    localparam int OB = $clog2(WORDS_PER_LINE);
    localparam int IB = $clog2(NUM_LINES);
    localparam int LW = 30 - OB;
    localparam int TW = 30 - OB - IB;

    typedef enum logic {
        LOOKUP = 1'b0,
        REFILL = 1'b1
    } state_t;

    // Handshake: a refill word transfers on any cycle where mem_req and mem_ready are both high;
    // mem_addr holds steady until then, and mem_ready without mem_req is ignored.
    state_t                state_q, state_d;
    logic [NUM_LINES-1:0]  valid_q, valid_d;
    logic [OB-1:0]         cnt_q, cnt_d;
    logic [LW-1:0]         line_q, line_d;
    logic                  flush_pend_q, flush_pend_d;
    logic [31:0]           hit_q, hit_d, miss_q, miss_d;

    logic [TW-1:0]         tag_mem  [NUM_LINES];
    logic [31:0]           data_mem [NUM_LINES*WORDS_PER_LINE];

    logic [OB-1:0]         offset;
    logic [IB-1:0]         index;
    logic [TW-1:0]         tag;
    logic [IB-1:0]         refill_idx;
    logic [TW-1:0]         refill_tag;
    logic                  last_word;
    logic                  fill_we;
    logic                  hit;
    logic                  unused_pc_bits;

    assign offset         = pc[2+OB-1:2];
    assign index          = pc[2+OB+IB-1:2+OB];
    assign tag            = pc[31:2+OB+IB];
    assign unused_pc_bits = ^pc[1:0];

    assign refill_idx = line_q[IB-1:0];
    assign refill_tag = line_q[LW-1:IB];
    assign last_word  = (cnt_q == OB'(WORDS_PER_LINE - 1));
    assign fill_we    = (state_q == REFILL) && mem_ready;
    assign hit        = valid_q[index] && (tag_mem[index] == tag);

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
    assign state_dbg  = state_q;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        cnt_d        = cnt_q;
        line_d       = line_q;
        flush_pend_d = flush_pend_q;
        hit_d        = hit_q;
        miss_d       = miss_q;
        stall        = 1'b1;
        instr        = '0;
        mem_req      = 1'b0;
        mem_addr     = {line_q, cnt_q, 2'b00};

        case (state_q)
            LOOKUP: begin
                if (hit) begin
                    stall = 1'b0;
                    instr = data_mem[{index, offset}];
                    hit_d = hit_q + 32'd1;
                end else begin
                    miss_d  = miss_q + 32'd1;
                    line_d  = pc[31:2+OB];
                    cnt_d   = '0;
                    state_d = REFILL;
                end
                // The lookup above already used the pre-flush valid bits.
                if (flush) begin
                    valid_d = '0;
                end
            end
            REFILL: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    cnt_d = cnt_q + OB'(1);
                    if (last_word) begin
                        if (!flush_pend_q) begin
                            valid_d[refill_idx] = 1'b1;
                        end
                        flush_pend_d = 1'b0;
                        state_d      = LOOKUP;
                    end
                end
                // A flush landing on the final word still leaves the line invalid.
                if (flush) begin
                    valid_d      = '0;
                    flush_pend_d = !(mem_ready && last_word);
                end
            end
            default: state_d = LOOKUP;
        endcase

        if (reset) begin
            stall   = 1'b1;
            instr   = '0;
            mem_req = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= LOOKUP;
            valid_q      <= '0;
            cnt_q        <= '0;
            line_q       <= '0;
            flush_pend_q <= 1'b0;
            hit_q        <= '0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            cnt_q        <= cnt_d;
            line_q       <= line_d;
            flush_pend_q <= flush_pend_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
        end
    end

    // Tag and data arrays need no reset: the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[{refill_idx, cnt_q}] <= mem_rdata;
            if (last_word) begin
                tag_mem[refill_idx] <= refill_tag;
            end
        end
    end
endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed scenarios plus random fetch streams
// checked against a line-level model of valid/tag state and hit/miss counts.
module tb_icache_dm;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        stall;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic        state_dbg;

    int checks   = 0;
    int failures = 0;

    bit          m_valid [16];
    logic [23:0] m_tag   [16];
    logic [31:0] exp_hits;
    logic [31:0] exp_misses;

    icache_dm dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .instr      (instr),
        .stall      (stall),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    // Main memory: each word holds its own address xor a fixed pattern.
    assign mem_rdata = mem_addr ^ 32'hA5A50000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    // One fetch of address a starting in a LOOKUP cycle. On a miss the refill is
    // followed through; the re-lookup is left to the next call.
    // mode: 0 ready always, 1 ready one cycle in three, 2 random ready and pc churn.
    // flush_at: cycle of the fetch (0 = lookup cycle) to pulse flush, -1 for none.
    task automatic access(input logic [31:0] a, input int mode, input int flush_at);
        int          idx;
        logic [23:0] tg;
        bit          hit;
        bit          fl_seen;
        logic [31:0] base;
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
        int          done;
        int          k;
        idx       = int'(a[7:4]);
        tg        = a[31:8];
        exp_instr = {a[31:2], 2'b00} ^ 32'hA5A50000;
        pc        = a;
        flush     = (flush_at == 0);
        mem_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        hit       = m_valid[idx] && (m_tag[idx] == tg);
        @(negedge clk);
        checks++;
        if (hit) begin
            if (stall !== 1'b0 || instr !== exp_instr || mem_req !== 1'b0) begin
                failures++;
                $display("FAIL hit pc=%h: stall=%b instr=%h mem_req=%b, required stall=0 instr=%h mem_req=0",
                         a, stall, instr, mem_req, exp_instr);
            end
            exp_hits++;
        end else begin
            if (stall !== 1'b1 || mem_req !== 1'b0) begin
                failures++;
                $display("FAIL miss_detect pc=%h: stall=%b mem_req=%b, required stall=1 mem_req=0",
                         a, stall, mem_req);
            end
            exp_misses++;
        end
        if (flush_at == 0) model_clear();
        tick();
        flush = 1'b0;
        if (!hit) begin
            base    = {a[31:4], 4'b0000};
            done    = 0;
            fl_seen = 1'b0;
            k       = 0;
            while (done < 4 && k < 64) begin
                k++;
                flush = (k == flush_at);
                case (mode)
                    0:       mem_ready = 1'b1;
                    1:       mem_ready = ((k % 3) == 0);
                    default: mem_ready = 1'($urandom_range(0, 1));
                endcase
                if (mode == 2) pc = $urandom;
                exp_addr = base + 32'(4 * done);
                @(negedge clk);
                checks++;
                if (mem_req !== 1'b1 || stall !== 1'b1 || mem_addr !== exp_addr) begin
                    failures++;
                    $display("FAIL refill pc=%h cycle %0d: mem_req=%b stall=%b mem_addr=%h, required mem_req=1 stall=1 mem_addr=%h",
                             a, k, mem_req, stall, mem_addr, exp_addr);
                end
                if (flush) begin
                    fl_seen = 1'b1;
                    model_clear();
                end
                if (mem_ready) done++;
                tick();
            end
            flush     = 1'b0;
            mem_ready = 1'b0;
            pc        = a;
            checks++;
            if (done != 4 || (mode == 0 && k != 4) || (mode == 1 && k != 12)) begin
                failures++;
                $display("FAIL penalty pc=%h: words=%0d refill_cycles=%0d, required words=4 cycles=%0d",
                         a, done, k, (mode == 1) ? 12 : 4);
            end
            if (!fl_seen) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        pc        = 32'h0;
        flush     = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || mem_req !== 1'b0 || instr !== 32'h0 ||
            hit_count !== 32'h0 || miss_count !== 32'h0 || state_dbg !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: stall=%b mem_req=%b instr=%h hits=%0d misses=%0d state=%b, required 1 0 0 0 0 0",
                     stall, mem_req, instr, hit_count, miss_count, state_dbg);
        end
        tick();
        reset      = 1'b0;
        mem_ready  = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        model_clear();
    endtask

    task automatic test_fill();
        access(32'h0, 0, -1);
        access(32'h0, 0, -1);
        checks++;
        if (hit_count !== 32'd1 || miss_count !== 32'd1) begin
            failures++;
            $display("FAIL fill_counters: hits=%0d misses=%0d, required 1 1", hit_count, miss_count);
        end
    endtask

    task automatic test_hits();
        for (int i = 1; i < 4; i++) access(32'(4 * i), 0, -1);
        checks++;
        if (hit_count !== 32'd4 || miss_count !== 32'd1) begin
            failures++;
            $display("FAIL hits_counters: hits=%0d misses=%0d, required 4 1", hit_count, miss_count);
        end
    endtask

    task automatic test_conflict();
        access(32'h100, 0, -1);
        access(32'h100, 0, -1);
        access(32'h0, 0, -1);
        access(32'h0, 0, -1);
        checks++;
        if (hit_count !== exp_hits || miss_count !== exp_misses || miss_count !== 32'd3) begin
            failures++;
            $display("FAIL conflict_counters: hits=%0d misses=%0d, required %0d %0d",
                     hit_count, miss_count, exp_hits, exp_misses);
        end
    endtask

    task automatic test_wait_states();
        access(32'h40, 1, -1);
        access(32'h40, 0, -1);
        checks++;
        if (hit_count !== exp_hits || miss_count !== exp_misses) begin
            failures++;
            $display("FAIL wait_counters: hits=%0d misses=%0d, required %0d %0d",
                     hit_count, miss_count, exp_hits, exp_misses);
        end
    endtask

    task automatic test_reset_mid_refill();
        pc        = 32'h80;
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_miss: stall=%b mem_req=%b, required 1 0", stall, mem_req);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'(32'h80 + 4 * i)) begin
                failures++;
                $display("FAIL mid_reset_refill word %0d: mem_req=%b mem_addr=%h, required 1 %h",
                         i, mem_req, mem_addr, 32'(32'h80 + 4 * i));
            end
            tick();
        end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || stall !== 1'b1 || instr !== 32'h0 ||
            hit_count !== 32'h0 || miss_count !== 32'h0) begin
            failures++;
            $display("FAIL async_reset: mem_req=%b stall=%b instr=%h hits=%0d misses=%0d, required 0 1 0 0 0",
                     mem_req, stall, instr, hit_count, miss_count);
        end
        repeat (2) @(posedge clk);
        #1;
        reset      = 1'b0;
        mem_ready  = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        model_clear();
        access(32'h80, 0, -1);
        access(32'h80, 0, -1);
        checks++;
        if (hit_count !== 32'd1 || miss_count !== 32'd1) begin
            failures++;
            $display("FAIL post_reset_counters: hits=%0d misses=%0d, required 1 1", hit_count, miss_count);
        end
    endtask

    task automatic test_flush();
        access(32'hC0, 0, 2);
        access(32'hC0, 0, -1);
        access(32'hC0, 0, -1);
        access(32'h0, 0, -1);
        access(32'h0, 0, 0);
        access(32'h0, 0, -1);
        access(32'h0, 0, -1);
        checks++;
        if (hit_count !== exp_hits || miss_count !== exp_misses) begin
            failures++;
            $display("FAIL flush_counters: hits=%0d misses=%0d, required %0d %0d",
                     hit_count, miss_count, exp_hits, exp_misses);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          fl;
        for (int n = 0; n < 300; n++) begin
            a  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) |
                 (32'($urandom_range(0, 3)) << 2);
            fl = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1;
            access(a, 2, fl);
        end
        checks++;
        if (hit_count !== exp_hits || miss_count !== exp_misses) begin
            failures++;
            $display("FAIL random_counters: hits=%0d misses=%0d, required %0d %0d",
                     hit_count, miss_count, exp_hits, exp_misses);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_hits();
        test_conflict();
        test_wait_states();
        test_reset_mid_refill();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
